// File: rtl/keychain_pkg.sv
// Shared types and constants for the keychain datapath blocks.
package keychain_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} framer_state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

endpackage

// File: rtl/result_uart_framer.sv
// Frames one WIDTH-bit result as header, payload bytes MSB first and an XOR
// checksum, pacing each byte through the uart_transmit trigger/busy handshake.
module result_uart_framer
  import keychain_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter logic [7:0]  HEADER      = FRAME_HEADER,
  parameter int          ACK_TIMEOUT = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [WIDTH-1:0]  word_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [7:0]        byte_out,
  output logic              trigger_out,
  input  logic              busy_in,
  output logic              busy_out,
  output logic              done_out,
  output framer_state_t     dbg_state
);

  localparam int N     = WIDTH / 8;
  localparam int IDX_W = $clog2(N + 2);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N + 1);
  localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  // Handshake: a word transfers on a clock edge where valid_in & ready_out are
  // both high; valid_in outside IDLE is dropped, never queued.

  framer_state_t    state, state_next;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [7:0]       chk;
  logic [7:0]       chk_next;
  logic [7:0]       byte_q;
  logic             done_q;
  logic             live;
  logic             accept;
  logic             advance;
  logic             trigger;

  assign ready_out     = live && (state == IDLE);
  assign accept        = valid_in && ready_out;
  assign byte_out      = byte_q;
  assign trigger_out   = trigger;
  assign done_out      = done_q;
  assign busy_out      = (state != IDLE) || done_q;
  assign dbg_state     = state;
  assign shreg_shifted = shreg << 8;

  always_comb begin
    chk_next = '0;
    for (int i = 0; i < N; i++) begin
      chk_next = chk_next ^ word_in[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    trigger    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE:      if (accept) state_next = SEND;
      SEND: begin
        if (!busy_in) begin
          trigger    = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (busy_in)              state_next = WAIT_DONE;
        else if (cnt == CNT_LAST) advance    = 1'b1;
      end
      WAIT_DONE: if (!busy_in) advance = 1'b1;
      default:   state_next = IDLE;
    endcase
    if (advance) state_next = (idx == IDX_LAST) ? IDLE : SEND;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      live   <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      shreg  <= '0;
      chk    <= '0;
      byte_q <= '0;
      done_q <= 1'b0;
    end else begin
      live   <= 1'b1;
      done_q <= 1'b0;
      if (trigger)                           cnt <= '0;
      else if (state == WAIT_ACK && !busy_in) cnt <= cnt + 1'b1;
      if (accept) begin
        shreg  <= word_in;
        chk    <= chk_next;
        idx    <= '0;
        byte_q <= HEADER;
      end else if (advance) begin
        if (idx == IDX_LAST) begin
          done_q <= 1'b1;
          idx    <= '0;
        end else begin
          idx <= idx + 1'b1;
          // Header -> first payload byte needs no shift; later payload steps do.
          if (idx == '0)           byte_q <= shreg[WIDTH-1 -: 8];
          else if (idx == IDX_CHK) byte_q <= chk;
          else begin
            shreg  <= shreg_shifted;
            byte_q <= shreg_shifted[WIDTH-1 -: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_result_uart_framer.sv
// Directed and randomized frames against a byte-list reference model, with a
// simple uart_transmit busy model driving the handshake.
module tb_result_uart_framer;
  import keychain_pkg::*;

  localparam int WIDTH       = 16;
  localparam int ACK_TIMEOUT = 4;
  localparam int N           = WIDTH / 8;
  localparam int UART_BUSY   = 10;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b1;
  logic [WIDTH-1:0] word_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic [7:0]       byte_out;
  logic             trigger_out;
  logic             busy_in = 1'b0;
  logic             busy_out;
  logic             done_out;
  framer_state_t    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  result_uart_framer #(.WIDTH(WIDTH), .HEADER(8'hA5), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .word_in(word_in), .valid_in(valid_in),
    .ready_out(ready_out), .byte_out(byte_out), .trigger_out(trigger_out),
    .busy_in(busy_in), .busy_out(busy_out), .done_out(done_out), .dbg_state(dbg_state)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void build_expected(input logic [WIDTH-1:0] w);
    logic [7:0] c = 8'h00;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    for (int i = N - 1; i >= 0; i--) begin
      b = w[i*8 +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endfunction

  task automatic run_frame(input logic [WIDTH-1:0] w, input bit tmo, input int pre_busy,
                           input int hold, input bit inject);
    int cyc = 0, ntrig = 0, last_trig = -1, first_trig = -1, busy_cnt = 0, extra = 0;
    bit trig_prev = 0, fin = 0;
    bit ready_bad = 0, busy_bad = 0, gate_bad = 0, space_bad = 0;
    logic [7:0] e;
    exp_q.delete();
    build_expected(w);
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    busy_in  = (pre_busy > 0);
    repeat (pre_busy) begin @(posedge clk_in); #1; end
    check("ready_idle", ready_out, 1);
    valid_in = 1'b1;
    word_in  = w;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    word_in  = WIDTH'($urandom);
    while (!fin && cyc < 400) begin
      if (inject && cyc >= 4 && cyc < 8) begin
        valid_in = 1'b1;
        word_in  = '1;
      end else valid_in = 1'b0;
      if (tmo) busy_in = 1'b0;
      else if (trig_prev) begin busy_cnt = UART_BUSY; busy_in = 1'b1; end
      else if (busy_cnt > 0) begin busy_cnt--; busy_in = (busy_cnt > 0); end
      else busy_in = (cyc < hold);
      @(negedge clk_in);
      trig_prev = trigger_out;
      if (trigger_out && busy_in) gate_bad = 1;
      if (trigger_out) begin
        if (ntrig == 0) first_trig = cyc;
        else if (cyc - last_trig != (tmo ? ACK_TIMEOUT + 1 : UART_BUSY + 2)) space_bad = 1;
        last_trig = cyc;
        ntrig++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d_of_%0h", ntrig - 1, w), byte_out, e);
        end
      end
      if (!busy_out) busy_bad = 1;
      if (done_out) begin
        fin = 1;
        check("ready_on_done", ready_out, 1);
      end else if (ready_out) ready_bad = 1;
      @(posedge clk_in); #1;
      cyc++;
    end
    valid_in = 1'b0;
    busy_in  = 1'b0;
    check("done_seen", fin, 1);
    check("trig_count", ntrig, N + 2);
    check("first_trig_cycle", first_trig, tmo ? 0 : hold);
    check("trig_while_busy", gate_bad, 0);
    check("trig_spacing", space_bad, 0);
    check("ready_in_frame", ready_bad, 0);
    check("busy_out_gap", busy_bad, 0);
    if (inject) begin
      repeat (30) begin
        @(negedge clk_in);
        if (trigger_out) extra++;
      end
      check("no_second_frame", extra, 0);
    end
  endtask

  initial begin
    int nt;
    #2 rst_n_in = 1'b0;
    #1;
    check("rst_ready", ready_out, 0);
    check("rst_byte", byte_out, 0);
    check("rst_trigger", trigger_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check("ready_after_release", ready_out, 1);

    run_frame(16'h1234, 0, 0, 0, 0);
    run_frame(16'h0000, 0, 0, 0, 0);
    run_frame(16'h5A3C, 0, 20, 3, 0);
    run_frame(16'hBEEF, 1, 0, 0, 0);
    run_frame(16'h1234, 0, 0, 0, 1);

    // Abort a frame after its second byte has been triggered.
    @(posedge clk_in); #1;
    valid_in = 1'b1;
    word_in  = 16'h1234;
    busy_in  = 1'b0;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    nt = 0;
    for (int i = 0; i < 40 && nt < 2; i++) begin
      @(negedge clk_in);
      if (trigger_out) nt++;
    end
    check("reset_setup_triggers", nt, 2);
    #2 rst_n_in = 1'b0;
    #1;
    check("mid_rst_ready", ready_out, 0);
    check("mid_rst_byte", byte_out, 0);
    check("mid_rst_trigger", trigger_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_done", done_out, 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check("ready_after_mid_rst", ready_out, 1);
    check("busy_after_mid_rst", busy_out, 0);
    run_frame(16'h0102, 0, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      run_frame(WIDTH'($urandom), 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
